if_id_queue: RTL and testbench

- Decoupling instruction queue between the instruction-fetch stage (PC register and fetch) and the decode stage.
- Buffers up to DEPTH fetched {pc, inst} pairs in a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Fetch keeps running while decode stalls for a short time.
- A branch/jump redirect flushes all buffered entries.

---
 rtl/if_id_queue_pkg.sv | 24 ++
 rtl/if_id_queue_mem.sv | 26 ++
 rtl/if_id_queue.sv | 88 ++++++++
 tb/tb_if_id_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared word constants for the fetch/decode queue.
// Provides the word width, the zero word and the NOP encoding.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef NOP_INST
`define NOP_INST 32'h0000_0000
`endif

package if_id_queue_pkg;

  localparam int WORD_W = `WORD_WIDTH;

  localparam logic [WORD_W-1:0] ZERO_WORD =
    WORD_W'(`ZERO_WORD);

  // sll $0,$0,0 encodes as all zeros
  localparam logic [WORD_W-1:0] NOP_INST =
    WORD_W'(`NOP_INST);

endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x (2W) entry store, sync write, comb read.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module if_id_queue_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [2*W-1:0]   wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [2*W-1:0]   rdata
);

  logic [2*W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: FWFT {pc, inst} queue between fetch and decode.
// Ports: clk, rst (sync, high), flush, in_* push side,
//        out_* pop side, count = occupancy 0..DEPTH.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int W     = WORD_W,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_pc,
  input  logic [W-1:0]   in_inst,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_pc,
  output logic [W-1:0]   out_pc_plus4,
  output logic [W-1:0]   out_inst,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL =
    (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic [2*W-1:0]   w_rdata;
  logic [W-1:0]     w_head_pc;
  logic [W-1:0]     w_head_inst;

  // ready looks only at registered occupancy,
  // so a full queue refuses a push even on a pop
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  if_id_queue_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata ({in_pc, in_inst}),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + 1'b1;
        (w_pop && !w_push): r_count <= r_count - 1'b1;
        default:            r_count <= r_count;
      endcase
    end
  end

  assign w_head_pc   = w_rdata[2*W-1:W];
  assign w_head_inst = w_rdata[W-1:0];

  // empty queue shows a bubble, not stale storage
  assign out_pc = out_valid ? w_head_pc : ZERO_WORD;
  assign out_pc_plus4 =
    out_valid ? w_head_pc + W'(4) : ZERO_WORD;
  assign out_inst =
    out_valid ? w_head_inst : NOP_INST;

  assign count = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed checks for the fetch/decode queue.
// Drives after each posedge, checks before the next.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_tot = 0;
  int n_bad = 0;
  logic [31:0] nxt;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .out_inst     (out_inst),
    .count        (count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(
    input logic [31:0] pc);
    return pc ^ 32'hA500_0000;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_p4", out_pc_plus4, 32'd0);
    chk("rst_inst", out_inst, 32'd0);

    // single push, 1-cycle latency
    in_valid = 1'b1; in_pc = 32'h0;
    in_inst = 32'h2408_0005;
    chk("nobypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_pc", out_pc, 32'h0);
    chk("p1_p4", out_pc_plus4, 32'h4);
    chk("p1_inst", out_inst, 32'h2408_0005);
    chk("p1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("p1_empty", 32'(count), 32'd0);

    // fill to full, extra push dropped
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc = 32'(4 * i);
      in_inst = ins(32'(4 * i));
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h10; in_inst = ins(32'h10);
    step();
    in_valid = 1'b0;
    chk("full_drop", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      chk("drain_inst", out_inst, ins(32'(4 * i)));
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // steady push+pop with pointer wrap
    nxt = 32'h100;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = nxt;
      in_inst = ins(nxt);
      step();
      nxt += 4;
    end
    chk("pp_count0", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("pp_head", out_pc, 32'h100 + 32'(4 * k));
      chk("pp_count", 32'(count), 32'd2);
      in_pc = nxt; in_inst = ins(nxt);
      step();
      nxt += 4;
    end
    chk("pp_inst", out_inst, ins(32'h128));

    // flush with push and pop pending
    out_ready = 1'b0;
    in_pc = nxt; in_inst = ins(nxt);
    step();
    chk("fl_pre", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1;
    in_pc = 32'hDEAD_0000; in_inst = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_inst", out_inst, 32'd0);
    chk("fl_pc", out_pc, 32'd0);
    step();
    chk("fl_gone", 32'(count), 32'd0);

    // stall: head stable while queue fills
    in_valid = 1'b1; in_pc = 32'h200;
    in_inst = 32'h1111_1111;
    step();
    chk("st_count1", 32'(count), 32'd1);
    nxt = 32'h204;
    for (int k = 0; k < 5; k++) begin
      chk("st_pc", out_pc, 32'h200);
      chk("st_inst", out_inst, 32'h1111_1111);
      in_pc = nxt; in_inst = ins(nxt);
      step();
      nxt += 4;
    end
    in_valid = 1'b0;
    chk("st_count", 32'(count), 32'd4);
    chk("st_ready", 32'(in_ready), 32'd0);

    // full queue refuses push even with a pop
    in_valid = 1'b1; in_pc = 32'h300;
    in_inst = ins(32'h300);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fp_count", 32'(count), 32'd3);
    chk("fp_head", out_pc, 32'h204);
    step();
    out_ready = 1'b0;
    chk("rm_pre", 32'(count), 32'd2);

    // reset beats push and pop
    rst = 1'b1; in_valid = 1'b1;
    in_pc = 32'h400; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rm_count", 32'(count), 32'd0);
    chk("rm_ready", 32'(in_ready), 32'd1);
    chk("rm_valid", 32'(out_valid), 32'd0);

    // pc+4 wraps modulo 2^32
    in_valid = 1'b1; in_pc = 32'hFFFF_FFFC;
    in_inst = 32'h0000_0020;
    step();
    in_valid = 1'b0;
    chk("wr_pc", out_pc, 32'hFFFF_FFFC);
    chk("wr_p4", out_pc_plus4, 32'h0);

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end

endmodule
